// File: rtl/avr_pkg.sv
// avr_pkg: shared fetch constants, state encoding and two-word opcode decode
//   PC_W_DEFAULT        default program counter / word address width
//   NOP                 opcode issued as the idle instruction
//   LDS_MASK/LDS_MATCH  LDS/STS first-word pattern 1001_00x_xxxxx_0000
//   JMP_MASK/JMP_MATCH  JMP/CALL first-word pattern 1001_010x_xxxx_11xx
//   fetch_state_t       FILL (fetch in flight), RUN (data each cycle), OP2 (waiting for second word)
//   is_two_word()       true when a word opens a two-word instruction
package avr_pkg;
    localparam int PC_W_DEFAULT = 9;
    localparam logic [15:0] NOP = 16'h0000;
    localparam logic [15:0] LDS_MASK = 16'hFC0F;
    localparam logic [15:0] LDS_MATCH = 16'h9000;
    localparam logic [15:0] JMP_MASK = 16'hFE0C;
    localparam logic [15:0] JMP_MATCH = 16'h940C;

    typedef enum logic [1:0] {FILL, RUN, OP2} fetch_state_t;

    function automatic logic is_two_word(input logic [15:0] w);
        return ((w & LDS_MASK) == LDS_MATCH) || ((w & JMP_MASK) == JMP_MATCH);
    endfunction
endpackage

// File: rtl/avr_fetch_if.sv
// avr_fetch_if: program memory and CPU-side signals of the fetch sequencer
//   p_addr      program memory word address (registered)
//   p_data      program memory data, valid the cycle after p_addr
//   stall       CPU cannot accept a new instr this cycle
//   br_take     redirect fetch to br_target (1-cycle pulse)
//   br_target   word address of the redirect
//   instr       instruction word to the CPU
//   instr_valid instr/instr_pc (and op2 when op2_valid) are valid
//   instr_pc    word address of instr
//   op2         second word of a two-word instruction
//   op2_valid   op2 is valid, only together with instr_valid
//   master: fetch controller side; slave: CPU + memory side
interface avr_fetch_if import avr_pkg::*; #(
    parameter int PC_W = PC_W_DEFAULT
);
    logic [PC_W-1:0] p_addr;
    logic [15:0]     p_data;
    logic            stall;
    logic            br_take;
    logic [PC_W-1:0] br_target;
    logic [15:0]     instr;
    logic            instr_valid;
    logic [PC_W-1:0] instr_pc;
    logic [15:0]     op2;
    logic            op2_valid;

    modport master (
        output p_addr, instr, instr_valid, instr_pc, op2, op2_valid,
        input  p_data, stall, br_take, br_target
    );

    modport slave (
        input  p_addr, instr, instr_valid, instr_pc, op2, op2_valid,
        output p_data, stall, br_take, br_target
    );
endinterface

// File: rtl/avr_fetch_skid.sv
// avr_fetch_skid: one-entry word+address skid buffer with load/consume/flush
//   clk, rst        clock, synchronous active-high reset
//   load            capture d_word/d_addr (only issued while empty)
//   consume         release the held entry
//   flush           discard the held entry; beats load and consume
//   d_word, d_addr  incoming word and its address
//   full            an entry is held
//   q_word, q_addr  held word and its address
module avr_fetch_skid #(
    parameter int PC_W = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            consume,
    input  logic            flush,
    input  logic [15:0]     d_word,
    input  logic [PC_W-1:0] d_addr,
    output logic            full,
    output logic [15:0]     q_word,
    output logic [PC_W-1:0] q_addr
);
    always_ff @(posedge clk) begin
        if (rst || flush)
            full <= 1'b0;
        else if (load)
            full <= 1'b1;
        else if (consume)
            full <= 1'b0;
        if (rst) begin
            q_word <= '0;
            q_addr <= '0;
        end else if (load && !flush) begin
            q_word <= d_word;
            q_addr <= d_addr;
        end
    end

    a_no_overwrite: assert property (@(posedge clk) disable iff (rst) !(load && full));
endmodule

// File: rtl/avr_fetch_ctrl.sv
// avr_fetch_ctrl: instruction fetch sequencer with PC, stall skid, branch redirect and two-word merge
//   clk, rst   clock, synchronous active-high reset (dominates everything)
//   f          avr_fetch_if.master: p_addr/p_data to program memory,
//              stall/br_take/br_target from the CPU, instr/instr_valid/
//              instr_pc/op2/op2_valid to the CPU
//   PC_W       word address width; RESET_VEC pc loaded on reset
module avr_fetch_ctrl import avr_pkg::*; #(
    parameter int              PC_W      = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] RESET_VEC = '0
) (
    input logic         clk,
    input logic         rst,
    avr_fetch_if.master f
);
    fetch_state_t state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d, fa_q, ha_q, ha_d, ipc_q, ipc_d;
    logic [15:0] hw_q, hw_d, instr_q, instr_d, op2_q, op2_d;
    logic iv_q, iv_d, ov_q, ov_d;
    logic sk_full, sk_load, sk_consume;
    logic [15:0] sk_word, src_word;
    logic [PC_W-1:0] sk_addr, src_addr;

    // fa_q is the address whose data is on p_data this cycle; a held skid
    // entry is older than p_data, so it is always consumed first.
    assign src_word = sk_full ? sk_word : f.p_data;
    assign src_addr = sk_full ? sk_addr : fa_q;

    // While stalled pc holds, so p_data keeps re-reading the next word and
    // only the first stalled word needs saving.
    assign sk_load    = f.stall && !f.br_take && state_q != FILL && !sk_full;
    assign sk_consume = !f.stall && !f.br_take && sk_full;

    avr_fetch_skid #(.PC_W(PC_W)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load    (sk_load),
        .consume (sk_consume),
        .flush   (f.br_take),
        .d_word  (f.p_data),
        .d_addr  (fa_q),
        .full    (sk_full),
        .q_word  (sk_word),
        .q_addr  (sk_addr)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        hw_d    = hw_q;
        ha_d    = ha_q;
        instr_d = instr_q;
        iv_d    = iv_q;
        ipc_d   = ipc_q;
        op2_d   = op2_q;
        ov_d    = ov_q;
        if (f.br_take) begin
            state_d = FILL;
            pc_d    = f.br_target;
            instr_d = NOP;
            iv_d    = 1'b0;
            ov_d    = 1'b0;
        end else if (!f.stall) begin
            pc_d = pc_q + 1'b1;
            iv_d = 1'b0;
            ov_d = 1'b0;
            if (state_q == FILL) begin
                state_d = RUN;
            end else if (state_q == OP2) begin
                state_d = RUN;
                instr_d = hw_q;
                ipc_d   = ha_q;
                op2_d   = src_word;
                iv_d    = 1'b1;
                ov_d    = 1'b1;
            end else if (is_two_word(src_word)) begin
                state_d = OP2;
                hw_d    = src_word;
                ha_d    = src_addr;
            end else begin
                instr_d = src_word;
                ipc_d   = src_addr;
                iv_d    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            pc_q    <= RESET_VEC;
            fa_q    <= RESET_VEC;
            hw_q    <= NOP;
            ha_q    <= '0;
            instr_q <= NOP;
            iv_q    <= 1'b0;
            ipc_q   <= '0;
            op2_q   <= '0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fa_q    <= pc_q;
            hw_q    <= hw_d;
            ha_q    <= ha_d;
            instr_q <= instr_d;
            iv_q    <= iv_d;
            ipc_q   <= ipc_d;
            op2_q   <= op2_d;
            ov_q    <= ov_d;
        end
    end

    assign f.p_addr      = pc_q;
    assign f.instr       = instr_q;
    assign f.instr_valid = iv_q;
    assign f.instr_pc    = ipc_q;
    assign f.op2         = op2_q;
    assign f.op2_valid   = ov_q;

    a_op2_with_instr: assert property (@(posedge clk) disable iff (rst) ov_q |-> iv_q);
endmodule

// File: tb/tb_avr_fetch_ctrl.sv
// tb_avr_fetch_ctrl: directed self-checking bench for avr_fetch_ctrl
module tb_avr_fetch_ctrl;
    import avr_pkg::*;
    localparam int PC_W = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] mem [0:511];

    avr_fetch_if #(.PC_W(PC_W)) ifc ();

    avr_fetch_ctrl #(.PC_W(PC_W), .RESET_VEC(9'd0)) dut (
        .clk (clk),
        .rst (rst),
        .f   (ifc)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) ifc.p_data <= mem[ifc.p_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_issue(input string tag, input logic [15:0] w, input logic [PC_W-1:0] a);
        check({tag, ".iv"}, 32'(ifc.instr_valid), 32'd1);
        check({tag, ".instr"}, 32'(ifc.instr), 32'(w));
        check({tag, ".pc"}, 32'(ifc.instr_pc), 32'(a));
        check({tag, ".ov"}, 32'(ifc.op2_valid), 32'd0);
    endtask

    task automatic expect_pair(input string tag, input logic [15:0] w, input logic [PC_W-1:0] a,
                               input logic [15:0] o);
        check({tag, ".iv"}, 32'(ifc.instr_valid), 32'd1);
        check({tag, ".ov"}, 32'(ifc.op2_valid), 32'd1);
        check({tag, ".instr"}, 32'(ifc.instr), 32'(w));
        check({tag, ".op2"}, 32'(ifc.op2), 32'(o));
        check({tag, ".pc"}, 32'(ifc.instr_pc), 32'(a));
    endtask

    task automatic expect_idle(input string tag);
        check({tag, ".iv"}, 32'(ifc.instr_valid), 32'd0);
        check({tag, ".ov"}, 32'(ifc.op2_valid), 32'd0);
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".p_addr"}, 32'(ifc.p_addr), 32'd0);
        check({tag, ".instr"}, 32'(ifc.instr), 32'd0);
        check({tag, ".pc"}, 32'(ifc.instr_pc), 32'd0);
        check({tag, ".op2"}, 32'(ifc.op2), 32'd0);
        expect_idle(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        step();
        step();
        expect_reset(tag);
        rst = 1'b0;
    endtask

    initial begin
        ifc.stall = 1'b0;
        ifc.br_take = 1'b0;
        ifc.br_target = '0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[0] = 16'hE0A4; mem[1] = 16'h50A1; mem[2] = 16'h50A2; mem[3] = 16'h0000;
        mem[4] = 16'h9100; mem[5] = 16'h0100; mem[6] = 16'h0000;
        mem[9'h010] = 16'hABCD;
        mem[9'h1F0] = 16'h1234; mem[9'h1F1] = 16'h5678;
        mem[9'h1FE] = 16'h1111; mem[9'h1FF] = 16'h2222;

        // straight line and LDS merge
        do_reset("a.rst");
        step(); expect_idle("a.fill"); check("a.fill.p_addr", 32'(ifc.p_addr), 32'd1);
        step(); expect_issue("a.i0", 16'hE0A4, 9'd0);
        step(); expect_issue("a.i1", 16'h50A1, 9'd1);
        step(); expect_issue("a.i2", 16'h50A2, 9'd2);
        step(); expect_issue("a.i3", 16'h0000, 9'd3);
        step(); expect_idle("a.op2wait");
        step(); expect_pair("a.lds", 16'h9100, 9'd4, 16'h0100);
        step(); expect_issue("a.i6", 16'h0000, 9'd6);

        // stall in RUN, then stall in OP2
        do_reset("b.rst");
        step(); step(); expect_issue("b.i0", 16'hE0A4, 9'd0);
        step(); expect_issue("b.i1", 16'h50A1, 9'd1);
        ifc.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_issue("b.hold", 16'h50A1, 9'd1);
            check("b.hold.p_addr", 32'(ifc.p_addr), 32'd3);
        end
        ifc.stall = 1'b0;
        step(); expect_issue("b.i2", 16'h50A2, 9'd2);
        step(); expect_issue("b.i3", 16'h0000, 9'd3);
        step(); expect_idle("b.op2wait");
        ifc.stall = 1'b1;
        step(); expect_idle("b.op2stall1");
        step(); expect_idle("b.op2stall2");
        ifc.stall = 1'b0;
        step(); expect_pair("b.lds", 16'h9100, 9'd4, 16'h0100);
        step(); expect_issue("b.i6", 16'h0000, 9'd6);

        // branch redirect, branch beating stall, wrap
        do_reset("c.rst");
        step(); step(); expect_issue("c.i0", 16'hE0A4, 9'd0);
        ifc.br_take = 1'b1; ifc.br_target = 9'h1F0;
        step(); expect_idle("c.bub1"); check("c.br.p_addr", 32'(ifc.p_addr), 32'h1F0);
        ifc.br_take = 1'b0;
        step(); expect_idle("c.bub2");
        step(); expect_issue("c.t0", 16'h1234, 9'h1F0);
        step(); expect_issue("c.t1", 16'h5678, 9'h1F1);
        ifc.stall = 1'b1; ifc.br_take = 1'b1; ifc.br_target = 9'h010;
        step(); expect_idle("c.brstall"); check("c.brstall.p_addr", 32'(ifc.p_addr), 32'h010);
        ifc.stall = 1'b0; ifc.br_take = 1'b0;
        step(); step(); expect_issue("c.t10", 16'hABCD, 9'h010);
        ifc.br_take = 1'b1; ifc.br_target = 9'h1FE;
        step(); expect_idle("c.wbub");
        ifc.br_take = 1'b0;
        step(); step(); expect_issue("c.w1fe", 16'h1111, 9'h1FE);
        check("c.wrap.p_addr", 32'(ifc.p_addr), 32'd0);
        step(); expect_issue("c.w1ff", 16'h2222, 9'h1FF);
        step(); expect_issue("c.w000", 16'hE0A4, 9'd0);
        mem[9'h1FF] = 16'h940C;
        ifc.br_take = 1'b1; ifc.br_target = 9'h1FF;
        step(); ifc.br_take = 1'b0;
        step(); step(); expect_idle("c.jmpwait");
        step(); expect_pair("c.jmp", 16'h940C, 9'h1FF, 16'hE0A4);
        step(); expect_issue("c.after", 16'h50A1, 9'd1);

        // reset during OP2 and during a stall with the skid full
        do_reset("d.rst");
        for (int i = 0; i < 6; i++) step();
        expect_idle("d.op2wait");
        rst = 1'b1;
        step(); expect_reset("d.rst_op2");
        rst = 1'b0;
        step(); expect_idle("d.fill");
        step(); expect_issue("d.i0", 16'hE0A4, 9'd0);
        ifc.stall = 1'b1;
        step(); step();
        rst = 1'b1;
        step(); expect_reset("d.rst_skid");
        rst = 1'b0; ifc.stall = 1'b0;
        step(); step(); expect_issue("d.r0", 16'hE0A4, 9'd0);
        step(); expect_issue("d.r1", 16'h50A1, 9'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
